soc_bram_ctl_wait: RTL and testbench

- Parametrised successor to the single-cycle SoC block-RAM controller.
- Sits behind the MMIO unit's RAM slave port (sstb/sack/srw/saddr/sdtw/sdtr).
- Adds:
  - configurable read/write wait states;
  - per-byte write masks;
  - a dedicated flush/abort input that cancels an in-flight access without resetting memory contents;
  - a busy indicator.
- Memory is four byte-wide banks forming one 32-bit word per address.

---
 rtl/soc_defs.sv | 25 ++
 rtl/soc_bram_bank.sv | 28 ++
 rtl/soc_bram_ctl_wait.sv | 157 +++++++++++++++
 tb/tb_soc_bram_ctl_wait.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_defs.sv
// Shared definitions for the wait-state block-RAM controller:
// FSM encodings, access-direction constant, latency limit and lane helper.
package soc_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic RW_WRITE    = 1'b1;
    localparam int   LATENCY_MAX = 15;
    localparam int   CNT_W       = 4;
    localparam int   LANES       = 4;

    // Per-lane write enables for a commit of the given request.
    function automatic logic [LANES-1:0] lane_we(
        input logic             commit,
        input logic             rw,
        input logic [LANES-1:0] mask
    );
        lane_we = (commit && rw == RW_WRITE) ? mask : '0;
    endfunction

endpackage

// File: rtl/soc_bram_bank.sv
// One byte-wide synchronous RAM lane.
// Ports: i_clk, i_we, i_addr, i_din[7:0] in; o_dout[7:0] registered out.
module soc_bram_bank #(
  parameter int    ADDR_WIDTH = 8,
  parameter string DATA       = ""
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_din,
  output logic [7:0]            o_dout
);

  logic [7:0] mem_q [2**ADDR_WIDTH];
  logic [7:0] dout_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_din;
      dout_q        <= i_din;
    end else begin
      dout_q <= mem_q[i_addr];
    end
  end

  assign o_dout = dout_q;

endmodule

// File: rtl/soc_bram_ctl_wait.sv
// Block-RAM slave with wait states, byte write masks, flush and busy.
// Ports: i_clk/i_reset/i_flush, request i_stb/i_rw/i_addr/i_dwrite/i_wmask,
// response o_dread/o_ack, status o_busy.
module soc_bram_ctl_wait
    import soc_defs::*;
#(
    parameter int    ADDR_WIDTH = 8,
    parameter int    LATENCY    = 0,
    parameter string DATA0      = "",
    parameter string DATA1      = "",
    parameter string DATA2      = "",
    parameter string DATA3      = ""
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_stb,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_dwrite,
    input  logic [3:0]            i_wmask,
    output logic [31:0]           o_dread,
    output logic                  o_ack,
    output logic                  o_busy
);

    if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_lat_chk
        $error("soc_bram_ctl_wait: LATENCY must be 0..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [31:0]           hold_q, hold_d;
    logic                  enter_ack;

    logic                  idle;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_din;
    logic [31:0]           ram_dout;
    logic                  req_rw;
    logic [3:0]            req_mask;
    logic [3:0]            ram_we;

    assign idle = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        enter_ack = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_stb) begin
                    addr_d  = i_addr;
                    rw_d    = i_rw;
                    wdata_d = i_dwrite;
                    wmask_d = i_wmask;
                    if (LATENCY == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any transition; an uncommitted write is dropped.
        if (i_flush || i_reset) begin
            state_d   = IDLE;
            cnt_d     = '0;
            enter_ack = 1'b0;
        end
    end

    // Zero-latency requests hit the RAM straight from the inputs.
    assign req_rw   = idle ? i_rw     : rw_q;
    assign req_mask = idle ? i_wmask  : wmask_q;
    assign ram_addr = idle ? i_addr   : addr_q;
    assign ram_din  = idle ? i_dwrite : wdata_q;
    assign ram_we   = lane_we(enter_ack, req_rw, req_mask);

    for (genvar n = 0; n < 4; n++) begin : g_lane
        localparam string FILE = (n == 0) ? DATA0 :
                                 (n == 1) ? DATA1 :
                                 (n == 2) ? DATA2 : DATA3;
        soc_bram_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA       (FILE)
        ) u_bank (
            .i_clk  (i_clk),
            .i_we   (ram_we[n]),
            .i_addr (ram_addr),
            .i_din  (ram_din[8*n +: 8]),
            .o_dout (ram_dout[8*n +: 8])
        );
    end

    // RAM output is live only in ACK; keep it afterwards.
    always_comb begin
        hold_d = hold_q;
        if (state_q == ACK) begin
            hold_d = ram_dout;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            hold_q  <= hold_d;
        end
    end

    assign o_ack   = (state_q == ACK);
    assign o_busy  = !idle;
    assign o_dread = (state_q == ACK) ? ram_dout : hold_q;

endmodule

// File: tb/tb_soc_bram_ctl_wait.sv
// Scoreboard bench for soc_bram_ctl_wait: a LATENCY=3 and a LATENCY=0
// instance, expected acks queued at issue and checked by monitors.
module tb_soc_bram_ctl_wait;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done0 = 1'b0;

    exp_t q3[$];
    exp_t q0[$];

    // LATENCY=3 instance
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stb = 1'b0;
    logic        rw = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] dw = '0;
    logic [3:0]  wm = '0;
    logic [31:0] dr;
    logic        ack;
    logic        busy;

    // LATENCY=0 instance
    logic        rst0 = 1'b1;
    logic        stb0 = 1'b0;
    logic        rw0 = 1'b0;
    logic [7:0]  addr0 = '0;
    logic [31:0] dw0 = '0;
    logic [3:0]  wm0 = '0;
    logic [31:0] dr0;
    logic        ack0;
    logic        busy0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    soc_bram_ctl_wait #(
        .ADDR_WIDTH (8),
        .LATENCY    (LAT)
    ) u_dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_flush  (flush),
        .i_stb    (stb),
        .i_rw     (rw),
        .i_addr   (addr),
        .i_dwrite (dw),
        .i_wmask  (wm),
        .o_dread  (dr),
        .o_ack    (ack),
        .o_busy   (busy)
    );

    soc_bram_ctl_wait #(
        .ADDR_WIDTH (8),
        .LATENCY    (0)
    ) u_dut0 (
        .i_clk    (clk),
        .i_reset  (rst0),
        .i_flush  (1'b0),
        .i_stb    (stb0),
        .i_rw     (rw0),
        .i_addr   (addr0),
        .i_dwrite (dw0),
        .i_wmask  (wm0),
        .o_dread  (dr0),
        .o_ack    (ack0),
        .o_busy   (busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, want, cyc);
        end
    endtask

    task automatic expect3(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q3.push_back(e);
    endtask

    task automatic expect0(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q0.push_back(e);
    endtask

    // Drive a one-cycle strobe; returns one cycle after the strobe cycle.
    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        stb  = 1'b1;
        rw   = w;
        addr = a;
        dw   = d;
        wm   = m;
        tick();
        stb = 1'b0;
    endtask

    task automatic req(input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] want);
        expect3(want, cyc + 1 + LAT);
        issue(w, a, d, m);
        repeat (LAT + 2) tick();
    endtask

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            total++;
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL ack3_unexpected cyc=%0d data=%h", cyc, dr);
            end else begin
                exp_t e;
                e = q3.pop_front();
                if (dr !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ack3 cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, dr, e.cyc, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL ack0_unexpected cyc=%0d data=%h", cyc, dr0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (dr0 !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ack0 cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, dr0, e.cyc, e.data);
                end
            end
        end
    end

    // Zero-latency instance
    initial begin
        repeat (3) tick();
        rst0 = 1'b0;
        tick();
        expect0(32'hDEADBEEF, cyc + 1);
        stb0 = 1'b1; rw0 = 1'b1; addr0 = 8'h00;
        dw0 = 32'hDEADBEEF; wm0 = 4'hF;
        tick();
        stb0 = 1'b0;
        chk("l0_wr_busy", {31'd0, busy0}, 32'd1);
        tick();
        chk("l0_wr_idle", {31'd0, busy0}, 32'd0);
        tick();
        expect0(32'hDEADBEEF, cyc + 1);
        stb0 = 1'b1; rw0 = 1'b0; addr0 = 8'h00;
        tick();
        chk("l0_rd_busy", {31'd0, busy0}, 32'd1);
        // strobe held into the ACK cycle is ignored
        addr0 = 8'h05;
        tick();
        stb0 = 1'b0;
        chk("l0_rd_idle", {31'd0, busy0}, 32'd0);
        repeat (3) tick();
        chk("l0_hold", dr0, 32'hDEADBEEF);
        done0 = 1'b1;
    end

    // LATENCY=3 instance
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dread", dr, 32'd0);
        tick();

        req(1'b1, 8'h10, 32'h12345678, 4'hF, 32'h12345678);
        req(1'b0, 8'h10, 32'h0, 4'h0, 32'h12345678);

        req(1'b1, 8'h20, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD);
        req(1'b1, 8'h20, 32'h11223344, 4'b0101, 32'hAA22CC44);
        req(1'b0, 8'h20, 32'h0, 4'h0, 32'hAA22CC44);

        // flush two cycles after strobe
        req(1'b1, 8'h30, 32'h0, 4'hF, 32'h0);
        issue(1'b1, 8'h30, 32'hCAFEF00D, 4'hF);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        req(1'b0, 8'h30, 32'h0, 4'h0, 32'h0);

        // flush in the last wait cycle, right before commit
        issue(1'b1, 8'h30, 32'hCAFEF00D, 4'hF);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_late_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        req(1'b0, 8'h30, 32'h0, 4'h0, 32'h0);

        // flush coinciding with ACK: ack and write survive
        expect3(32'h5555AAAA, cyc + 1 + LAT);
        issue(1'b1, 8'h40, 32'h5555AAAA, 4'hF);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        req(1'b0, 8'h40, 32'h0, 4'h0, 32'h5555AAAA);

        // strobes while busy and during ACK are dropped
        req(1'b1, 8'h01, 32'h01010101, 4'hF, 32'h01010101);
        req(1'b1, 8'h02, 32'h02020202, 4'hF, 32'h02020202);
        expect3(32'h01010101, cyc + 1 + LAT);
        issue(1'b0, 8'h01, 32'h0, 4'h0);
        issue(1'b0, 8'h02, 32'h0, 4'h0);
        repeat (2) tick();
        issue(1'b0, 8'h02, 32'h0, 4'h0);
        repeat (3) tick();
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("dread_hold", dr, 32'h01010101);

        // empty mask write
        req(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h12345678);
        req(1'b0, 8'h10, 32'h0, 4'h0, 32'h12345678);

        // strobe together with flush
        stb = 1'b1; flush = 1'b1; rw = 1'b0; addr = 8'h10;
        tick();
        stb = 1'b0; flush = 1'b0;
        chk("stb_flush_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();

        // reset during WAIT
        issue(1'b0, 8'h20, 32'h0, 4'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_dread", dr, 32'd0);
        repeat (4) tick();
        req(1'b0, 8'h20, 32'h0, 4'h0, 32'hAA22CC44);

        for (int i = 0; i < 200 && !done0; i++) tick();
        chk("l0_done", {31'd0, done0}, 32'd1);
        chk("q3_left", q3.size(), 32'd0);
        chk("q0_left", q0.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
